// File: rtl/rf_multiport.sv
// Multi-ported register file: 2 async reads, 2 byte-masked sync writes,
// optional write->read bypass, hardwired zero register and busy scoreboard.
module rf_multiport #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra_addr,
    output logic [DW-1:0]   ra_data,
    output logic            ra_busy,
    input  logic [AW-1:0]   rb_addr,
    output logic [DW-1:0]   rb_data,
    output logic            rb_busy,
    input  logic            w0_en,
    input  logic [AW-1:0]   w0_addr,
    input  logic [DW/8-1:0] w0_be,
    input  logic [DW-1:0]   w0_data,
    input  logic            w1_en,
    input  logic [AW-1:0]   w1_addr,
    input  logic [DW/8-1:0] w1_be,
    input  logic [DW-1:0]   w1_data,
    input  logic            res_en,
    input  logic [AW-1:0]   res_addr
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            for (int b = 0; b < NB; b++) begin
                if (w0_en && w0_be[b] && w0_addr == AW'(r))
                    mem_d[r][8*b +: 8] = w0_data[8*b +: 8];
                if (w1_en && w1_be[b] && w1_addr == AW'(r))
                    mem_d[r][8*b +: 8] = w1_data[8*b +: 8];
            end
            if ((w0_en && w0_addr == AW'(r)) || (w1_en && w1_addr == AW'(r)))
                busy_d[r] = 1'b0;
            // A new reservation outranks a retiring write to the same register
            if (res_en && res_addr == AW'(r))
                busy_d[r] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            mem_d[0]  = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++)
                mem_q[r] <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mem_q[a];
        if (BYPASS != 0) begin
            for (int b = 0; b < NB; b++) begin
                if (w1_en && w1_be[b] && w1_addr == a)
                    v[8*b +: 8] = w1_data[8*b +: 8];
                else if (w0_en && w0_be[b] && w0_addr == a)
                    v[8*b +: 8] = w0_data[8*b +: 8];
            end
        end
        if (ZERO_REG != 0 && a == '0)
            v = '0;
        return v;
    endfunction

    // Gate with rst_n so bypassed write data cannot leak out during reset
    always_comb begin
        ra_data = rst_n ? rd(ra_addr) : '0;
        rb_data = rst_n ? rd(rb_addr) : '0;
        ra_busy = rst_n & busy_q[ra_addr];
        rb_busy = rst_n & busy_q[rb_addr];
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed-vector bench for rf_multiport: default build plus a
// ZERO_REG=0 / BYPASS=0 build driven from the same inputs.
module tb_rf_multiport;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra_addr, rb_addr;
    logic [31:0] ra_data, rb_data, ra_data0, rb_data0;
    logic        ra_busy, rb_busy, ra_busy0, rb_busy0;
    logic        w0_en, w1_en, res_en;
    logic [4:0]  w0_addr, w1_addr, res_addr;
    logic [3:0]  w0_be, w1_be;
    logic [31:0] w0_data, w1_data;

    int vec_cnt;
    int err_cnt;

    rf_multiport u_dut (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
        .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_be(w0_be), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_be(w1_be), .w1_data(w1_data),
        .res_en(res_en), .res_addr(res_addr)
    );

    rf_multiport #(.ZERO_REG(0), .BYPASS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .ra_data(ra_data0), .ra_busy(ra_busy0),
        .rb_addr(rb_addr), .rb_data(rb_data0), .rb_busy(rb_busy0),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_be(w0_be), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_be(w1_be), .w1_data(w1_data),
        .res_en(res_en), .res_addr(res_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0_en;
        logic [4:0]  w0_addr;
        logic [3:0]  w0_be;
        logic [31:0] w0_data;
        logic        w1_en;
        logic [4:0]  w1_addr;
        logic [3:0]  w1_be;
        logic [31:0] w1_data;
        logic        res_en;
        logic [4:0]  res_addr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] era;
        logic [31:0] erb;
        logic        eab;
        logic        ebb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic e0, input logic [4:0] a0, input logic [3:0] b0,
        input logic [31:0] d0,
        input logic e1, input logic [4:0] a1, input logic [3:0] b1,
        input logic [31:0] d1,
        input logic re, input logic [4:0] rad,
        input logic [4:0] ra, input logic [4:0] rb,
        input logic [31:0] era, input logic [31:0] erb,
        input logic eab, input logic ebb);
        vec_t v;
        v.w0_en = e0; v.w0_addr = a0; v.w0_be = b0; v.w0_data = d0;
        v.w1_en = e1; v.w1_addr = a1; v.w1_be = b1; v.w1_data = d1;
        v.res_en = re; v.res_addr = rad;
        v.ra = ra; v.rb = rb;
        v.era = era; v.erb = erb; v.eab = eab; v.ebb = ebb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        w0_en = 0; w0_addr = 0; w0_be = 0; w0_data = 0;
        w1_en = 0; w1_addr = 0; w1_be = 0; w1_data = 0;
        res_en = 0; res_addr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        idle();
        ra_addr = 0;
        rb_addr = 0;
        rst_n   = 1'b0;

        // Writes driven while in reset must not appear on the outputs
        #1;
        w0_en = 1; w0_addr = 3; w0_be = 4'hF; w0_data = 32'h12345678;
        ra_addr = 3;
        #1;
        chk("rst_hold_ra", ra_data, 32'h0);
        chk("rst_hold_ra_busy", {31'b0, ra_busy}, 32'h0);
        repeat (2) @(posedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 32; i++) begin
            ra_addr = 5'(i);
            rb_addr = 5'(31 - i);
            #1;
            chk($sformatf("rst_ra[%0d]", i), ra_data, 32'h0);
            chk($sformatf("rst_rb[%0d]", 31 - i), rb_data, 32'h0);
            chk($sformatf("rst_busy[%0d]", i), {30'b0, ra_busy, rb_busy}, 32'h0);
            chk($sformatf("rst_dut0[%0d]", i), ra_data0, 32'h0);
        end

        //           w0: en addr be data        w1: en addr be data   res     ra rb  exp_ra exp_rb busyA busyB
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    3,7,  32'h0,32'h0,0,0));
        vt.push_back(mk(1,3,4'hF,32'h11223344, 0,0,4'h0,32'h0,       0,0,    3,3,  32'h11223344,32'h11223344,0,0));
        vt.push_back(mk(1,3,4'h5,32'hAABBCCDD, 0,0,4'h0,32'h0,       0,0,    3,4,  32'h11BB33DD,32'h0,0,0));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    3,3,  32'h11BB33DD,32'h11BB33DD,0,0));
        vt.push_back(mk(1,7,4'hF,32'h11111111, 1,7,4'h3,32'h00002222,0,0,    7,3,  32'h11112222,32'h11BB33DD,0,0));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    7,7,  32'h11112222,32'h11112222,0,0));
        vt.push_back(mk(1,0,4'hF,32'hFFFFFFFF, 0,0,4'h0,32'h0,       1,0,    0,7,  32'h0,32'h11112222,0,0));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    0,0,  32'h0,32'h0,0,0));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       1,5,    5,5,  32'h0,32'h0,0,0));
        vt.push_back(mk(1,5,4'hF,32'h55555555, 0,0,4'h0,32'h0,       1,5,    5,5,  32'h55555555,32'h55555555,1,1));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    5,3,  32'h55555555,32'h11BB33DD,1,0));
        vt.push_back(mk(0,0,4'h0,32'h0,        1,5,4'h0,32'hDEADBEEF,0,0,    5,5,  32'h55555555,32'h55555555,1,1));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    5,3,  32'h55555555,32'h11BB33DD,0,0));
        vt.push_back(mk(1,9,4'hC,32'h12345678, 1,9,4'h8,32'hA5000000,0,0,    9,9,  32'hA5340000,32'hA5340000,0,0));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    9,7,  32'hA5340000,32'h11112222,0,0));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       1,10,   10,10,32'h0,32'h0,0,0));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       1,10,   10,10,32'h0,32'h0,1,1));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    10,5, 32'h0,32'h55555555,1,0));
        vt.push_back(mk(1,10,4'h1,32'h000000EE,0,0,4'h0,32'h0,       0,0,    10,10,32'h000000EE,32'h000000EE,1,1));
        vt.push_back(mk(0,0,4'h0,32'h0,        0,0,4'h0,32'h0,       0,0,    10,10,32'h000000EE,32'h000000EE,0,0));

        foreach (vt[i]) begin
            w0_en = vt[i].w0_en; w0_addr = vt[i].w0_addr;
            w0_be = vt[i].w0_be; w0_data = vt[i].w0_data;
            w1_en = vt[i].w1_en; w1_addr = vt[i].w1_addr;
            w1_be = vt[i].w1_be; w1_data = vt[i].w1_data;
            res_en = vt[i].res_en; res_addr = vt[i].res_addr;
            ra_addr = vt[i].ra; rb_addr = vt[i].rb;
            #1;
            chk($sformatf("v%0d_ra", i), ra_data, vt[i].era);
            chk($sformatf("v%0d_rb", i), rb_data, vt[i].erb);
            chk($sformatf("v%0d_ra_busy", i), {31'b0, ra_busy}, {31'b0, vt[i].eab});
            chk($sformatf("v%0d_rb_busy", i), {31'b0, rb_busy}, {31'b0, vt[i].ebb});
            step();
        end
        idle();

        // Register 0 behaves as a normal register when not hardwired
        ra_addr = 0;
        rb_addr = 5;
        #1;
        chk("zr0_data", ra_data0, 32'hFFFFFFFF);
        chk("zr0_busy", {31'b0, ra_busy0}, 32'h1);
        chk("zr1_data", ra_data, 32'h0);
        chk("zr1_busy", {31'b0, ra_busy}, 32'h0);
        chk("dut0_rb5", rb_data0, 32'h55555555);

        // Bypass on vs off in the same cycle as the write
        step();
        w0_en = 1; w0_addr = 12; w0_be = 4'hF; w0_data = 32'hCAFEF00D;
        ra_addr = 12;
        #1;
        chk("byp_on", ra_data, 32'hCAFEF00D);
        chk("byp_off", ra_data0, 32'h0);
        step();
        idle();
        #1;
        chk("stored_on", ra_data, 32'hCAFEF00D);
        chk("stored_off", ra_data0, 32'hCAFEF00D);

        // Async reset between edges with a write pending
        step();
        w0_en = 1; w0_addr = 3; w0_be = 4'hF; w0_data = 32'h99999999;
        ra_addr = 3;
        rb_addr = 12;
        #1;
        chk("pre_rst_byp", ra_data, 32'h99999999);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ra", ra_data, 32'h0);
        chk("mid_rst_rb", rb_data, 32'h0);
        chk("mid_rst_rb0", rb_data0, 32'h0);
        w0_en = 0;
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_ra", ra_data, 32'h0);
        chk("post_rst_ra0", ra_data0, 32'h0);
        chk("post_rst_rb", rb_data, 32'h0);
        ra_addr = 10;
        rb_addr = 0;
        #1;
        chk("post_rst_busy10", {31'b0, ra_busy}, 32'h0);
        chk("post_rst_busy0", {31'b0, rb_busy0}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
